// File: rtl/stepper_move_scheduler.sv
// ---------------------------------------------------------------------------
// stepper_move_scheduler
//
// Runs one stepper move at a time. A move is either a fixed N-step move or a
// home-seek toward the limit switch. The block sets the direction, waits a
// short setup time, then issues step pulses. Fixed moves use a linear
// accel/decel ramp on the step period. Home moves run at the slowest period.
// The scheduler sits between the read-sequence FSM, which is the command
// source, and the stepper driver pins.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   cmd_valid     command offered by the sequencer
//   cmd_ready     high only in IDLE; a command is taken on cmd_valid & cmd_ready
//   cmd_steps     step count for a fixed move (ignored for home moves)
//   cmd_dir       1 = UP (toward the limit switch), 0 = DOWN
//   cmd_home      1 = seek the limit switch at the slowest period
//   limit_switch  raw asynchronous limit input
//   step          step pulse to the driver
//   direction     direction to the driver; only changes when a command is taken
//   busy          high from command accept until the done pulse
//   done          one-cycle pulse when a move ends
//   limit_hit     set if the last move ended on the limit switch
//   steps_taken   step rising edges issued in the current or last move
// ---------------------------------------------------------------------------
module stepper_move_scheduler #(
    parameter int MAX_PERIOD        = 2048,
    parameter int MIN_PERIOD        = 512,
    parameter int RAMP_DELTA        = 16,
    parameter int STEP_PULSE_CYCLES = 8,
    parameter int DIR_SETUP_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_steps,
    input  logic        cmd_dir,
    input  logic        cmd_home,
    input  logic        limit_switch,
    output logic        step,
    output logic        direction,
    output logic        busy,
    output logic        done,
    output logic        limit_hit,
    output logic [15:0] steps_taken
);

    localparam logic [16:0] MAX_P      = 17'(MAX_PERIOD);
    localparam logic [16:0] MIN_P      = 17'(MIN_PERIOD);
    localparam logic [16:0] DELTA_P    = 17'(RAMP_DELTA);
    localparam logic [16:0] PULSE_LAST = 17'(STEP_PULSE_CYCLES - 1);
    localparam logic [15:0] SETUP_LAST = 16'(DIR_SETUP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        DONE
    } stateType;

    stateType    state;
    stateType    nextState;

    logic        limMeta;
    logic        limSync;

    logic        homeMove;
    logic [15:0] cmdStepsReg;
    logic [15:0] rampCnt;
    logic [15:0] setupCnt;
    logic [16:0] period;
    logic [16:0] curPeriod;
    logic [16:0] tick;

    logic        acceptCmd;
    logic        issueEdge;
    logic        abortOnLimit;
    logic        atBoundary;
    logic        moveComplete;

    logic [16:0] nextStepIndex;
    logic [16:0] remaining;
    logic [16:0] periodSum;
    logic [16:0] periodUp;
    logic [16:0] periodDown;

    // The limit switch is asynchronous to clk, so it passes through two
    // flops before anything looks at it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            limMeta <= 1'b0;
            limSync <= 1'b0;
        end else begin
            limMeta <= limit_switch;
            limSync <= limMeta;
        end
    end

    // tick counts cycles since the last step rising edge. curPeriod is the
    // length of the interval in progress. The next edge is due when tick
    // reaches curPeriod-1. On accept, tick is preloaded to the boundary, so
    // the first edge comes on the cycle right after SETUP.
    assign atBoundary    = (tick == curPeriod - 17'd1);
    assign moveComplete  = !homeMove && (steps_taken == cmdStepsReg);

    // Ramp arithmetic is done in 17 bits so the sums and differences never
    // wrap. remaining is the number of steps still to go after the edge that
    // is being issued now.
    assign nextStepIndex = {1'b0, steps_taken} + 17'd1;
    assign remaining     = {1'b0, cmdStepsReg} - nextStepIndex;
    assign periodSum     = period + DELTA_P;
    assign periodUp      = (periodSum > MAX_P) ? MAX_P : periodSum;
    assign periodDown    = (period >= MIN_P + DELTA_P) ? (period - DELTA_P) : MIN_P;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and control decode. At an interval boundary the checks run
    // in this order: a finished fixed move ends cleanly first; then a limit
    // abort (home moves, or fixed UP moves); otherwise the next edge is issued.
    always_comb begin
        nextState    = state;
        acceptCmd    = 1'b0;
        issueEdge    = 1'b0;
        abortOnLimit = 1'b0;
        cmd_ready    = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    acceptCmd = 1'b1;
                    if ((cmd_steps == 16'd0) && !cmd_home) begin
                        nextState = DONE;
                    end else begin
                        nextState = SETUP;
                    end
                end
            end
            SETUP: begin
                if (setupCnt == SETUP_LAST) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (atBoundary) begin
                    if (moveComplete) begin
                        nextState = DONE;
                    end else if (limSync && (homeMove || direction)) begin
                        abortOnLimit = 1'b1;
                        nextState    = DONE;
                    end else begin
                        issueEdge = 1'b1;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Move datapath: command capture, pulse shaping, ramp and status.
    // The ramp update at edge k sets the period of the interval after edge
    // k+1. The interval that starts at edge k uses the period as it stood
    // before the update, so curPeriod takes the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step        <= 1'b0;
            direction   <= 1'b0;
            busy        <= 1'b0;
            limit_hit   <= 1'b0;
            steps_taken <= 16'd0;
            homeMove    <= 1'b0;
            cmdStepsReg <= 16'd0;
            rampCnt     <= 16'd0;
            setupCnt    <= 16'd0;
            period      <= MAX_P;
            curPeriod   <= MAX_P;
            tick        <= 17'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (acceptCmd) begin
                        direction   <= cmd_dir;
                        busy        <= 1'b1;
                        limit_hit   <= 1'b0;
                        steps_taken <= 16'd0;
                        homeMove    <= cmd_home;
                        cmdStepsReg <= cmd_steps;
                        rampCnt     <= 16'd0;
                        setupCnt    <= 16'd0;
                        period      <= MAX_P;
                        curPeriod   <= MAX_P;
                        tick        <= MAX_P - 17'd1;
                        step        <= 1'b0;
                    end
                end
                SETUP: begin
                    setupCnt <= setupCnt + 16'd1;
                end
                RUN: begin
                    if (issueEdge) begin
                        step        <= 1'b1;
                        steps_taken <= steps_taken + 16'd1;
                        tick        <= 17'd0;
                        curPeriod   <= period;
                        if (!homeMove) begin
                            if (remaining <= {1'b0, rampCnt}) begin
                                period  <= periodUp;
                                rampCnt <= (rampCnt == 16'd0) ? 16'd0 : (rampCnt - 16'd1);
                            end else if (period > MIN_P) begin
                                period  <= periodDown;
                                rampCnt <= rampCnt + 16'd1;
                            end
                        end
                    end else begin
                        tick <= tick + 17'd1;
                        if (tick == PULSE_LAST) begin
                            step <= 1'b0;
                        end
                    end
                    if (abortOnLimit) begin
                        limit_hit <= 1'b1;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_move_scheduler.sv
// ---------------------------------------------------------------------------
// tb_stepper_move_scheduler
//
// Directed bench for stepper_move_scheduler built with small parameters
// (MAX=32, MIN=8, DELTA=8, PULSE=2, SETUP=2). Each table record describes one
// move and its hand-computed step-edge times, done time and final status.
// Times are in cycles relative to the accept edge. Hand-written sequences
// cover reset in the middle of a pulse and cmd_valid held high during a move.
// ---------------------------------------------------------------------------
module tb_stepper_move_scheduler;

    localparam int TIMEOUT = 1000;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic        cmd_home;
    logic        limit_switch;
    logic        step;
    logic        direction;
    logic        busy;
    logic        done;
    logic        limit_hit;
    logic [15:0] steps_taken;

    int checkCount = 0;
    int missCount  = 0;

    typedef struct {
        int steps;
        bit dir;
        bit home;
        bit limitLevel;
        int limitAfter;
        int expEdges;
        int expEdge[5];
        int expLast;
        int expDone;
        int expSteps;
        int expLimitHit;
    } vecT;

    vecT vecs[9];

    stepper_move_scheduler #(
        .MAX_PERIOD       (32),
        .MIN_PERIOD       (8),
        .RAMP_DELTA       (8),
        .STEP_PULSE_CYCLES(2),
        .DIR_SETUP_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_steps   (cmd_steps),
        .cmd_dir     (cmd_dir),
        .cmd_home    (cmd_home),
        .limit_switch(limit_switch),
        .step        (step),
        .direction   (direction),
        .busy        (busy),
        .done        (done),
        .limit_hit   (limit_hit),
        .steps_taken (steps_taken)
    );

    // 10-unit clock; outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: bumps the counters and reports a mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Waits, with a bounded loop, for done. rel is the cycle count from the
    // current falling edge, or -1 if the budget runs out.
    task automatic waitForDone(input int budget, output int rel);
        rel = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                rel = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Runs one table record: sets the limit level, offers the command,
    // records step rising edges and busy cycles until done, then checks it all.
    task automatic applyStimulus(input vecT v, input int idx);
        int   nEdges;
        int   edgeAt[32];
        int   lastEdge;
        int   busyCnt;
        int   doneRel;
        logic prevStep;
        bit   raised;
        nEdges   = 0;
        lastEdge = -1;
        busyCnt  = 0;
        doneRel  = -1;
        prevStep = 1'b0;
        raised   = 1'b0;
        for (int j = 0; j < 32; j++) edgeAt[j] = -1;

        limit_switch = v.limitLevel;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_steps = 16'(v.steps);
        cmd_dir   = v.dir;
        cmd_home  = v.home;
        checkOutput($sformatf("v%0d cmd_ready before accept", idx), int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;

        for (int i = 0; i < TIMEOUT; i++) begin
            if (step && !prevStep) begin
                if (nEdges < 32) edgeAt[nEdges] = i;
                nEdges++;
                lastEdge = i;
            end
            prevStep = step;
            if (busy) busyCnt++;
            if (v.limitAfter != 0 && !raised && nEdges == v.limitAfter) begin
                limit_switch = 1'b1;
                raised       = 1'b1;
            end
            if (done) begin
                doneRel = i;
                break;
            end
            @(negedge clk);
        end

        checkOutput($sformatf("v%0d done cycle", idx), doneRel, v.expDone);
        checkOutput($sformatf("v%0d edge count", idx), nEdges, v.expEdges);
        for (int j = 0; j < 5 && j < v.expEdges; j++) begin
            checkOutput($sformatf("v%0d edge %0d time", idx, j + 1), edgeAt[j], v.expEdge[j]);
        end
        if (v.expEdges > 0) begin
            checkOutput($sformatf("v%0d last edge time", idx), lastEdge, v.expLast);
        end
        checkOutput($sformatf("v%0d busy cycles", idx), busyCnt, v.expDone + 1);
        checkOutput($sformatf("v%0d steps_taken", idx), int'(steps_taken), v.expSteps);
        checkOutput($sformatf("v%0d limit_hit", idx), int'(limit_hit), v.expLimitHit);
        checkOutput($sformatf("v%0d direction", idx), int'(direction), int'(v.dir));

        @(negedge clk);
        checkOutput($sformatf("v%0d done after pulse", idx), int'(done), 0);
        checkOutput($sformatf("v%0d cmd_ready after done", idx), int'(cmd_ready), 1);
        checkOutput($sformatf("v%0d busy after done", idx), int'(busy), 0);
    endtask

    // Main sequence: reset checks, table vectors, then the hand sequences.
    initial begin
        int  doneRel;
        bit  found;
        bit  dirStable;

        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_steps    = 16'd0;
        cmd_dir      = 1'b0;
        cmd_home     = 1'b0;
        limit_switch = 1'b0;

        // Hand-computed moves. Edge times are relative to the accept edge.
        vecs[0] = '{steps:5,  dir:1'b1, home:1'b0, limitLevel:1'b0, limitAfter:0, expEdges:5,
                    expEdge:'{3, 35, 59, 75, 99}, expLast:99,  expDone:131, expSteps:5,  expLimitHit:0};
        vecs[1] = '{steps:0,  dir:1'b1, home:1'b0, limitLevel:1'b0, limitAfter:0, expEdges:0,
                    expEdge:'{-1, -1, -1, -1, -1}, expLast:-1, expDone:0,   expSteps:0,  expLimitHit:0};
        vecs[2] = '{steps:20, dir:1'b1, home:1'b0, limitLevel:1'b1, limitAfter:0, expEdges:0,
                    expEdge:'{-1, -1, -1, -1, -1}, expLast:-1, expDone:3,   expSteps:0,  expLimitHit:1};
        vecs[3] = '{steps:1,  dir:1'b0, home:1'b0, limitLevel:1'b0, limitAfter:0, expEdges:1,
                    expEdge:'{3, -1, -1, -1, -1},  expLast:3,  expDone:35,  expSteps:1,  expLimitHit:0};
        vecs[4] = '{steps:2,  dir:1'b1, home:1'b0, limitLevel:1'b0, limitAfter:0, expEdges:2,
                    expEdge:'{3, 35, -1, -1, -1},  expLast:35, expDone:59,  expSteps:2,  expLimitHit:0};
        vecs[5] = '{steps:20, dir:1'b0, home:1'b0, limitLevel:1'b1, limitAfter:0, expEdges:20,
                    expEdge:'{3, 35, 59, 75, 83},  expLast:227, expDone:259, expSteps:20, expLimitHit:0};
        vecs[6] = '{steps:0,  dir:1'b1, home:1'b1, limitLevel:1'b0, limitAfter:3, expEdges:3,
                    expEdge:'{3, 35, 67, -1, -1},  expLast:67, expDone:99,  expSteps:3,  expLimitHit:1};
        vecs[7] = '{steps:3,  dir:1'b1, home:1'b0, limitLevel:1'b0, limitAfter:0, expEdges:3,
                    expEdge:'{3, 35, 59, -1, -1},  expLast:59, expDone:91,  expSteps:3,  expLimitHit:0};
        vecs[8] = '{steps:7,  dir:1'b0, home:1'b1, limitLevel:1'b1, limitAfter:0, expEdges:0,
                    expEdge:'{-1, -1, -1, -1, -1}, expLast:-1, expDone:3,   expSteps:0,  expLimitHit:1};

        // Power-on reset values.
        repeat (3) @(negedge clk);
        checkOutput("reset step", int'(step), 0);
        checkOutput("reset direction", int'(direction), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset limit_hit", int'(limit_hit), 0);
        checkOutput("reset steps_taken", int'(steps_taken), 0);
        checkOutput("reset cmd_ready", int'(cmd_ready), 1);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset while the second step pulse is high: outputs drop at once,
        // and a following 1-step move behaves normally.
        limit_switch = 1'b0;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_steps = 16'd5;
        cmd_dir   = 1'b1;
        cmd_home  = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (step && steps_taken == 16'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("midpulse reached step 2", int'(found), 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("midpulse reset step", int'(step), 0);
        checkOutput("midpulse reset busy", int'(busy), 0);
        checkOutput("midpulse reset steps_taken", int'(steps_taken), 0);
        checkOutput("midpulse reset direction", int'(direction), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midpulse cmd_ready after release", int'(cmd_ready), 1);
        applyStimulus(vecs[3], 100);

        // cmd_valid is held high through a move with the opposite direction.
        // The second command must wait until the cycle after done.
        limit_switch = 1'b0;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_steps = 16'd2;
        cmd_dir   = 1'b1;
        cmd_home  = 1'b0;
        @(negedge clk);
        cmd_steps = 16'd1;
        cmd_dir   = 1'b0;
        checkOutput("held cmd_ready while busy", int'(cmd_ready), 0);
        dirStable = 1'b1;
        doneRel   = -1;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (direction != 1'b1) dirStable = 1'b0;
            if (done) begin
                doneRel = i;
                break;
            end
            @(negedge clk);
        end
        checkOutput("held first done cycle", doneRel, 59);
        checkOutput("held direction stable", int'(dirStable), 1);
        @(negedge clk);
        checkOutput("held cmd_ready after done", int'(cmd_ready), 1);
        checkOutput("held direction before second accept", int'(direction), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("held second accept direction", int'(direction), 0);
        checkOutput("held second accept busy", int'(busy), 1);
        waitForDone(TIMEOUT, doneRel);
        checkOutput("held second done cycle", doneRel, 35);
        checkOutput("held second steps_taken", int'(steps_taken), 1);

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
        $finish;
    end

endmodule
